// File: rtl/mem_arb_pkg.sv
// Shared types, constants and the byte-merge helper for the two-port RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW  = 30;
  localparam int unsigned DefDataW  = 32;
  // Widest data path the merge helper handles; narrower words are zero-extended.
  localparam int unsigned MergeMaxW = 64;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [0:0] {
    StIdle,
    StRmwRd
  } arb_state_e;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [MergeMaxW-1:0] byte_merge(
    input logic [MergeMaxW-1:0]   old_word,
    input logic [MergeMaxW-1:0]   new_word,
    input logic [MergeMaxW/8-1:0] be
  );
    logic [MergeMaxW-1:0] res;
    res = old_word;
    for (int k = 0; k < int'(MergeMaxW / 8); k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant; all zero while the FSM blocks new issues.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        if (last == PORT_I) gnt[PORT_D] = 1'b1;
        else                gnt[PORT_I] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-addressed synchronous RAM between the
// instruction-fetch port (I) and the load/store port (D).
// Define MEM_ARB_RMW_EN to honour d_be via a read-modify-write sequence; without it
// every store is a single-cycle full-word write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data,
  input  logic [DATA_W-1:0]   ram_q
);

  logic [1:0] arb_req, arb_gnt;
  logic       issue_en;
  logic       last_q, last_d;
  logic       i_pend_q, i_pend_d;
  logic       d_pend_q, d_pend_d;

`ifdef MEM_ARB_RMW_EN
  arb_state_e           state_q, state_d;
  logic [MergeMaxW-1:0] old_ext, new_ext, merge_full;
  logic [MergeMaxW/8-1:0] be_ext;
  logic [DATA_W-1:0]    merged;
  logic                 unused_merge;

  assign issue_en = (state_q == StIdle);

  // Widen to the helper's fixed width and merge the held store into the word just read.
  always_comb begin
    old_ext = '0;
    new_ext = '0;
    be_ext  = '0;
    old_ext[DATA_W-1:0]   = ram_q;
    new_ext[DATA_W-1:0]   = d_wdata;
    be_ext[DATA_W/8-1:0]  = d_be;
    merge_full            = byte_merge(old_ext, new_ext, be_ext);
    merged                = merge_full[DATA_W-1:0];
  end
  assign unused_merge = ^merge_full;
`else
  logic unused_be;
  assign issue_en  = 1'b1;
  assign unused_be = ^d_be;
`endif

  assign arb_req = {d_req, i_req};

  mem_arb_rr u_rr (
    .req  (arb_req),
    .last (last_q),
    .en   (issue_en),
    .gnt  (arb_gnt)
  );

  // Decode the winning access onto the RAM port and compute grants and next state.
  always_comb begin
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    i_pend_d    = 1'b0;
    d_pend_d    = 1'b0;
    last_d      = last_q;
`ifdef MEM_ARB_RMW_EN
    state_d     = state_q;
`endif
    if (arb_gnt[PORT_I]) begin
      ram_address = i_addr;
      i_gnt       = 1'b1;
      i_pend_d    = 1'b1;
      last_d      = PORT_I;
    end else if (arb_gnt[PORT_D]) begin
      if (!d_we) begin
        ram_address = d_addr;
        d_gnt       = 1'b1;
        d_pend_d    = 1'b1;
        last_d      = PORT_D;
`ifdef MEM_ARB_RMW_EN
      end else if (d_be == '0) begin
        // Nothing to write: complete immediately without touching the RAM.
        d_gnt  = 1'b1;
        last_d = PORT_D;
      end else if (&d_be) begin
        ram_address = d_addr;
        ram_wren    = 1'b1;
        ram_data    = d_wdata;
        d_gnt       = 1'b1;
        last_d      = PORT_D;
      end else begin
        // Partial store: fetch the old word now, no grant until the write cycle.
        ram_address = d_addr;
        state_d     = StRmwRd;
      end
`else
      end else begin
        ram_address = d_addr;
        ram_wren    = 1'b1;
        ram_data    = d_wdata;
        d_gnt       = 1'b1;
        last_d      = PORT_D;
      end
`endif
    end
`ifdef MEM_ARB_RMW_EN
    if (state_q == StRmwRd) begin
      ram_address = d_addr;
      ram_wren    = 1'b1;
      ram_data    = merged;
      d_gnt       = 1'b1;
      last_d      = PORT_D;
      state_d     = StIdle;
    end
`endif
  end

  // Arbitration history, read-return flags and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= PORT_I;
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
`ifdef MEM_ARB_RMW_EN
      state_q  <= StIdle;
`endif
    end else begin
      last_q   <= last_d;
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
`ifdef MEM_ARB_RMW_EN
      state_q  <= state_d;
`endif
    end
  end

  assign i_rvalid = i_pend_q;
  assign d_rvalid = d_pend_q;
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW       = 30;
  localparam int unsigned DW       = 32;
  localparam int unsigned MemWords = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_be        (d_be),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a bench-side preload port.
  logic [31:0] ram [MemWords];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)        ram[pre_addr] <= pre_data;
    else if (ram_wren) ram[ram_address[5:0]] <= ram_data;
    ram_q <= ram[ram_address[5:0]];
  end

  // Reference model state.
  logic [31:0] mem_exp [MemWords];
  logic        m_last;   // 0 = I granted last, 1 = D
  bit          m_rmw;    // next cycle completes a partial store
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] merge_ref(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    pre_we = 1'b1; pre_addr = 6'(a); pre_data = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
    mem_exp[a] = v;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_last = 1'b0;
    m_rmw  = 1'b0;
  endtask

  // One clock of checking; starts after a negedge with inputs already driven.
  task automatic step(output bit ei, output bit ed, output bit oi, output bit od);
    bit          ewe, srmw, rd_d, win_i, win_d;
    logic [5:0]  wa;
    logic [31:0] wd, ri, rdv;
    ei = 0; ed = 0; ewe = 0; srmw = 0; rd_d = 0; wa = '0; wd = '0; ri = '0; rdv = '0;
    #1;
    if (m_rmw) begin
      ed  = 1; ewe = 1; wa = d_addr[5:0];
      wd  = merge_ref(mem_exp[wa], d_wdata, d_be);
    end else begin
      win_d = d_req && (!i_req || m_last == 1'b0);
      win_i = i_req && !win_d;
      if (win_i) begin ei = 1; ri = mem_exp[i_addr[5:0]]; end
      if (win_d) begin
        if (!d_we) begin
          ed = 1; rd_d = 1; rdv = mem_exp[d_addr[5:0]];
`ifdef MEM_ARB_RMW_EN
        end else if (d_be == 4'h0) begin
          ed = 1;
        end else if (d_be == 4'hF) begin
          ed = 1; ewe = 1; wa = d_addr[5:0]; wd = d_wdata;
        end else begin
          srmw = 1;
`else
        end else begin
          ed = 1; ewe = 1; wa = d_addr[5:0]; wd = d_wdata;
`endif
        end
      end
    end
    oi = i_gnt;
    od = d_gnt;
    check("i_gnt", 32'(i_gnt), 32'(ei));
    check("d_gnt", 32'(d_gnt), 32'(ed));
    check("ram_wren", 32'(ram_wren), 32'(ewe));
    if (ewe) begin
      check("wr_addr", 32'(ram_address), 32'(d_addr));
      check("wr_data", ram_data, wd);
    end else if (ei) check("i_rd_addr", 32'(ram_address), 32'(i_addr));
    else if (rd_d || srmw) check("d_rd_addr", 32'(ram_address), 32'(d_addr));
    else check("idle_addr", 32'(ram_address), 32'd0);
    @(posedge clk);
    if (ewe) mem_exp[wa] = wd;
    m_rmw = srmw;
    if (ei) m_last = 1'b0;
    if (ed) m_last = 1'b1;
    #1;
    check("i_rvalid", 32'(i_rvalid), 32'(ei));
    if (ei) check("i_rdata", i_rdata, ri);
    check("d_rvalid", 32'(d_rvalid), 32'(rd_d));
    if (rd_d) check("d_rdata", d_rdata, rdv);
    @(negedge clk);
  endtask

  initial begin
    bit ei, ed, oi, od;
    int bad;
    rst_n = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0;
    d_wdata = '0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < int'(MemWords); k++) preload(k, $urandom);
    preload(4, 32'h20080005);

    // Reset values.
    check("rst_i_gnt", 32'(i_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_i_rvalid", 32'(i_rvalid), 0);
    check("rst_d_rvalid", 32'(d_rvalid), 0);
    check("rst_wren", 32'(ram_wren), 0);
    rst_n = 1'b1;

    // Single instruction read.
    i_req = 1; i_addr = 30'd4;
    step(ei, ed, oi, od);
    check("t1_gnt", 32'(oi), 1);
    check("t1_rvalid", 32'(i_rvalid), 1);
    check("t1_rdata", i_rdata, 32'h20080005);
    i_req = 0;

    // Tie for four cycles: D, I, D, I.
    i_req = 1; i_addr = 30'd12; d_req = 1; d_we = 0; d_addr = 30'd8;
    for (int k = 0; k < 4; k++) begin
      step(ei, ed, oi, od);
      check("t2_order_d", 32'(od), 32'(k % 2 == 0));
      check("t2_order_i", 32'(oi), 32'(k % 2 == 1));
    end
    i_req = 0; d_req = 0;

    // Full store then load back.
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 30'h10; d_wdata = 32'h11111111;
    step(ei, ed, oi, od);
    check("t3_store_gnt", 32'(od), 1);
    d_we = 0;
    step(ei, ed, oi, od);
    check("t3_load", d_rdata, 32'h11111111);
    d_req = 0;

    // Byte-masked store.
    preload(16, 32'hAABBCCDD);
    d_req = 1; d_we = 1; d_be = 4'b0001; d_addr = 30'h10; d_wdata = 32'h00000011;
    step(ei, ed, oi, od);
`ifdef MEM_ARB_RMW_EN
    check("t4_gnt_c1", 32'(od), 0);
    step(ei, ed, oi, od);
    check("t4_gnt_c2", 32'(od), 1);
    check("t4_mem", ram[16], 32'hAABBCC11);
`else
    check("t4_gnt_c1", 32'(od), 1);
    check("t4_mem", ram[16], 32'h00000011);
`endif
    d_req = 0;

    // Partial store with an instruction fetch arriving behind it.
    d_req = 1; d_we = 1; d_be = 4'b0110; d_addr = 30'd20; d_wdata = 32'h12345678;
    step(ei, ed, oi, od);
    if (ed) d_req = 0;
    i_req = 1; i_addr = 30'd5;
    step(ei, ed, oi, od);
    if (ed) d_req = 0;
`ifdef MEM_ARB_RMW_EN
    check("t5_i_blocked", 32'(oi), 0);
    check("t5_d_done", 32'(od), 1);
    step(ei, ed, oi, od);
    check("t5_i_after", 32'(oi), 1);
`else
    check("t5_i_after", 32'(oi), 1);
`endif
    i_req = 0; d_req = 0;

`ifdef MEM_ARB_RMW_EN
    // Reset pulse in the write cycle of a partial store aborts it.
    preload(32, 32'h12345678);
    d_req = 1; d_we = 1; d_be = 4'b1000; d_addr = 30'd32; d_wdata = 32'hFF000000;
    step(ei, ed, oi, od);
    check("t6_gnt_c1", 32'(od), 0);
    rst_n = 1'b0; d_req = 0;
    #1;
    check("t6_rst_gnt", 32'(d_gnt), 0);
    check("t6_rst_wren", 32'(ram_wren), 0);
    @(posedge clk); @(negedge clk);
    check("t6_mem_kept", ram[32], 32'h12345678);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("t6_post_i_gnt", 32'(i_gnt), 0);
    check("t6_post_d_gnt", 32'(d_gnt), 0);
    check("t6_post_i_rv", 32'(i_rvalid), 0);
    check("t6_post_d_rv", 32'(d_rvalid), 0);
    check("t6_post_wren", 32'(ram_wren), 0);
    check("t6_post_addr", 32'(ram_address), 0);
    d_req = 1;
    step(ei, ed, oi, od);
    step(ei, ed, oi, od);
    check("t6_retry_gnt", 32'(od), 1);
    check("t6_retry_mem", ram[32], 32'hFF345678);
    d_req = 0;
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1; i_addr = 30'($urandom_range(0, 63));
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = 30'($urandom_range(0, 63));
        d_wdata = $urandom;
        case ($urandom_range(0, 3))
          0:       d_be = 4'hF;
          1:       d_be = 4'h0;
          default: d_be = 4'($urandom);
        endcase
      end
      step(ei, ed, oi, od);
      if (ei) i_req = 0;
      if (ed) d_req = 0;
    end
    i_req = 0;
    for (int c = 0; c < 4 && d_req; c++) begin
      step(ei, ed, oi, od);
      if (ed) d_req = 0;
    end
    step(ei, ed, oi, od);

    bad = 0;
    for (int k = 0; k < int'(MemWords); k++) if (ram[k] !== mem_exp[k]) bad++;
    check("mem_final", 32'(bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, word-addressed main RAM between the CPU instruction-fetch port (I) and the load/store port (D). It sits between the core and the RAM and applies round-robin arbitration. It tracks the RAM's one-cycle synchronous read latency and returns read data to the correct requester. Byte-masked stores are performed as a read-modify-write sequence, because the RAM only supports full-word writes.

## Interface
- ADDR_W, 30, word address width; matches the RAM address port
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  instruction word address
- i_gnt  out  1  access issued this cycle
- i_rvalid  out  1  i_rdata valid, one cycle after i_gnt
- i_rdata  out  DATA_W  instruction read data
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables; be[k] covers bits 8k+7:8k; ignored for loads
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  access issued or completed this cycle
- d_rvalid  out  1  d_rdata valid, one cycle after a load's d_gnt
- d_rdata  out  DATA_W  load data
- ram_wren  out  1  RAM write enable
- ram_address  out  ADDR_W  RAM word address
- ram_data  out  DATA_W  RAM write data
- ram_q  in  DATA_W  RAM read data; valid the cycle after its address is presented

## Operation
- States: IDLE, RMW_RD.
- IDLE:
  - Picks one requester per cycle.
  - If only one requester is asserting req, that requester wins.
  - If both are asserting req, the port not granted last wins.
  - `last` resets to I, so D wins the first tie.
- Granted read (I, or D with d_we=0):
  - Drives ram_address and asserts gnt.
  - Sets the pending flag for that port.
  - The next cycle raises that port's rvalid, with rdata = ram_q.
- Granted full store (d_be all ones): ram_wren=1, ram_data=d_wdata, d_gnt=1, single cycle. A store never raises rvalid.
- Granted store with d_be == 0: d_gnt=1, ram_wren=0; treated as a no-op completion.
- Granted partial store:
  - IDLE drives ram_address=d_addr as a read with no gnt, then moves to RMW_RD.
  - RMW_RD writes merge(ram_q, d_wdata, d_be) with ram_wren=1 and asserts d_gnt.
  - RMW_RD then returns to IDLE. I is not granted in RMW_RD.
- `last` updates to the winning port on every gnt. An RMW updates it on its final cycle.
- Back-to-back reads are allowed. A new grant can be issued in the same cycle earlier data is returned on rvalid.
- When no access is issued, ram_wren=0, ram_address=0, ram_data=0.

## Timing
- All RAM-side outputs and gnt are combinational from the state, requests and `last`.
- rvalid and the pending flags are registered.
- Read latency: gnt in cycle N, rvalid in cycle N+1.
- Latencies:
  - Full store: 1 cycle.
  - Partial store: 2 cycles, with d_gnt in the second cycle.
  - Throughput: one access per cycle, except RMW, which costs 2.
- Requesters must not change request fields while req=1 and gnt=0. Dropping req before gnt is permitted outside RMW.
- Reset values: state=IDLE, last=I, pending flags=0, i_gnt=d_gnt=i_rvalid=d_rvalid=0, ram_wren=0.
- Reset asserted in RMW_RD aborts the sequence. No write occurs and no d_gnt is issued.

## Configuration
- Macro: MEM_ARB_RMW_EN.
- Defined: partial stores use the RMW sequence described above.
- Undefined:
  - d_be is ignored and every store is a single-cycle full-word write of d_wdata.
  - The RMW_RD state and the merge logic are removed.

## Structure
- Package mem_arb_pkg holds:
  - State enum (IDLE, RMW_RD).
  - Port-id constants PORT_I=0, PORT_D=1.
  - Default ADDR_W/DATA_W localparams.
  - Byte-merge function.
- Sub-module mem_arb_rr: 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot grant; grant is zero when the FSM blocks issue.

## Test plan
- Reset, then I read of 0x004 with ram[4]=0x20080005 → i_gnt in cycle 0; cycle 1 i_rvalid=1, i_rdata=0x20080005.
- i_req and d_req (load) asserted together for 4 cycles after reset → grant order D, I, D, I. Each rvalid lands on the correct port one cycle later.
- Full store to 0x010 of 0x11111111, then load of 0x010 → 1-cycle store, then d_rdata=0x11111111.
- With MEM_ARB_RMW_EN defined, ram[0x10]=0xAABBCCDD, store of 0x00000011 with d_be=4'b0001 → 2 cycles, d_gnt only on cycle 2, ram[0x10]=0xAABBCC11. With the macro undefined → 1 cycle, ram[0x10]=0x00000011.
- Partial store pending with i_req held → I is not granted in RMW_RD and is granted in the first cycle after.
- rst_n pulsed low during RMW_RD → RAM contents unchanged, no d_gnt. After release, outputs are zero and the retried store completes.
